// File: rtl/stage_if_pkg.sv
// Shared types for the instruction-fetch stage.
// State encoding, stall-bus layout and byte-lane helper.
package stage_if_pkg;

    typedef enum logic [2:0] {
        IF_IDLE  = 3'd0,
        IF_FETCH = 3'd1,
        IF_WAIT  = 3'd2,
        IF_DRAIN = 3'd3,
        IF_DONE  = 3'd4
    } if_state_e;

    localparam int StallW    = 6;
    localparam int StallIfId = 1;

    function automatic logic [31:0] put_byte(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        r[8*lane +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/stage_if.sv
// Instruction fetch: four byte reads per word, little-endian assembly,
// stall hold in DONE and EX branch redirect with one-deep drain.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [StallW-1:0] stall_i,
    input  logic              branch_enable_i,
    input  logic [31:0]       branch_addr_i,
    output logic              mem_req_o,
    output logic [31:0]       mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [7:0]        mem_rdata_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pco_q, pco_d;
    logic [31:0] inst_q, inst_d;
    logic        vld_q, vld_d;
    logic [31:0] merged;

    logic unused_stall;
    assign unused_stall = ^{stall_i[StallW-1:2], stall_i[0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pco_d   = pco_q;
        inst_d  = inst_q;
        vld_d   = vld_q;
        merged  = put_byte(buf_q, cnt_q, mem_rdata_i);

        if (branch_enable_i) begin
            pc_d    = branch_addr_i;
            cnt_d   = 2'd0;
            vld_d   = 1'b0;
            state_d = IF_FETCH;
            req_d   = 1'b1;
            addr_d  = branch_addr_i;
            // A request still in flight must be drained before refetching
            unique case (state_q)
                IF_WAIT, IF_DRAIN: begin
                    if (!mem_rvalid_i) begin
                        state_d = IF_DRAIN;
                        req_d   = 1'b0;
                        addr_d  = addr_q;
                    end
                end
                IF_FETCH: begin
                    if (mem_gnt_i) begin
                        state_d = IF_DRAIN;
                        req_d   = 1'b0;
                        addr_d  = addr_q;
                    end
                end
                default: ;
            endcase
        end else begin
            unique case (state_q)
                IF_IDLE: begin
                    state_d = IF_FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q + 32'(cnt_q);
                end
                IF_FETCH: begin
                    if (mem_gnt_i) begin
                        state_d = IF_WAIT;
                        req_d   = 1'b0;
                    end
                end
                IF_WAIT: begin
                    if (mem_rvalid_i) begin
                        buf_d = merged;
                        if (cnt_q == 2'd3) begin
                            state_d = IF_DONE;
                            vld_d   = 1'b1;
                            pco_d   = pc_q;
                            inst_d  = merged;
                        end else begin
                            cnt_d   = cnt_q + 2'd1;
                            state_d = IF_FETCH;
                            req_d   = 1'b1;
                            addr_d  = pc_q + 32'(cnt_q) + 32'd1;
                        end
                    end
                end
                IF_DRAIN: begin
                    if (mem_rvalid_i) begin
                        state_d = IF_FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q + 32'(cnt_q);
                    end
                end
                IF_DONE: begin
                    if (!stall_i[StallIfId]) begin
                        pc_d    = pc_q + 32'd4;
                        cnt_d   = 2'd0;
                        vld_d   = 1'b0;
                        state_d = IF_FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q + 32'd4;
                    end
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 2'd0;
            buf_q   <= 32'd0;
            req_q   <= 1'b0;
            addr_q  <= 32'd0;
            pco_q   <= 32'd0;
            inst_q  <= 32'd0;
            vld_q   <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pco_q   <= pco_d;
            inst_q  <= inst_d;
            vld_q   <= vld_d;
        end
    end

    assign mem_req_o    = req_q;
    assign mem_addr_o   = addr_q;
    assign pc_o         = pco_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = vld_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if with a byte-memory model of
// configurable read latency.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [5:0]  stall_i;
    logic        branch_enable_i;
    logic [31:0] branch_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [7:0]  mem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:4095];
    logic        rv_q;
    logic [7:0]  rd_q;
    int          pend;
    logic [11:0] paddr;
    int          lat;
    logic        force_rv;

    stage_if #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .stall_i         (stall_i),
        .branch_enable_i (branch_enable_i),
        .branch_addr_i   (branch_addr_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o)
    );

    always #5 clk = ~clk;

    assign mem_rvalid_i = rv_q | force_rv;
    assign mem_rdata_i  = force_rv ? 8'hFF : rd_q;

    // Memory returns one byte per grant, lat cycles after the grant edge
    always @(posedge clk) begin
        if (rst) begin
            rv_q <= 1'b0;
            pend <= 0;
        end else if (rdy) begin
            rv_q <= 1'b0;
            if (pend == 1) begin
                rv_q <= 1'b1;
                rd_q <= mem[paddr];
            end
            if (pend != 0) pend <= pend - 1;
            if (mem_req_o && mem_gnt_i) begin
                paddr <= mem_addr_o[11:0];
                if (lat == 1) begin
                    rv_q <= 1'b1;
                    rd_q <= mem[mem_addr_o[11:0]];
                end else begin
                    pend <= lat - 1;
                end
            end
        end
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem[a[11:0]+12'd3], mem[a[11:0]+12'd2],
                mem[a[11:0]+12'd1], mem[a[11:0]]};
    endfunction

    function automatic logic [97:0] mk(input logic r, input logic [31:0] a,
                                       input logic v, input logic [31:0] p,
                                       input logic [31:0] i);
        return {r, a, v, p, i};
    endfunction

    function automatic logic [97:0] snap();
        return {mem_req_o, mem_addr_o, inst_valid_o, pc_o, inst_o};
    endfunction

    task automatic chk(input string name, input logic [97:0] act,
                       input logic [97:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_word(input logic [31:0] base, input int k0,
                              input logic [31:0] exp);
        int n;
        bit got;
        n = k0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mem_req_o && mem_gnt_i) begin
                chk($sformatf("fw_addr%0d", n), 98'(mem_addr_o),
                    98'(base + 32'(n)));
                n++;
            end
            step();
            if (inst_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("fw_valid", 98'(got), 98'(1));
        chk("fw_bytes", 98'(n), 98'(4));
        chk("fw_pc", 98'(pc_o), 98'(base));
        chk("fw_inst", 98'(inst_o), 98'(exp));
    endtask

    typedef struct {
        logic [5:0]  stall;
        logic        gnt;
        logic [97:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w4;
        logic [31:0] wx;
        logic [31:0] bb;
        for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 7 + 3) & 255);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[256] = 8'hEF; mem[257] = 8'hBE;
        mem[258] = 8'hAD; mem[259] = 8'hDE;
        w4 = word_at(32'd4);

        tbl[0]  = '{6'd0, 1'b1, mk(1, 32'd0, 0, 0, 0)};
        tbl[1]  = '{6'd0, 1'b1, mk(0, 32'd0, 0, 0, 0)};
        tbl[2]  = '{6'd0, 1'b1, mk(1, 32'd1, 0, 0, 0)};
        tbl[3]  = '{6'd0, 1'b1, mk(0, 32'd1, 0, 0, 0)};
        tbl[4]  = '{6'd0, 1'b1, mk(1, 32'd2, 0, 0, 0)};
        tbl[5]  = '{6'd0, 1'b1, mk(0, 32'd2, 0, 0, 0)};
        tbl[6]  = '{6'd0, 1'b1, mk(1, 32'd3, 0, 0, 0)};
        tbl[7]  = '{6'd0, 1'b1, mk(0, 32'd3, 0, 0, 0)};
        tbl[8]  = '{6'd0, 1'b1, mk(0, 32'd3, 1, 0, 32'h13)};
        tbl[9]  = '{6'b000010, 1'b1, mk(0, 32'd3, 1, 0, 32'h13)};
        tbl[10] = '{6'b000010, 1'b1, mk(0, 32'd3, 1, 0, 32'h13)};
        tbl[11] = '{6'b000010, 1'b1, mk(0, 32'd3, 1, 0, 32'h13)};
        tbl[12] = '{6'b111101, 1'b1, mk(1, 32'd4, 0, 0, 32'h13)};

        rst = 1'b1; rdy = 1'b1; stall_i = '0;
        branch_enable_i = 1'b0; branch_addr_i = '0;
        mem_gnt_i = 1'b1; lat = 1; force_rv = 1'b0;
        step();
        step();
        chk("reset", snap(), mk(0, 0, 0, 0, 0));
        rst = 1'b0;

        foreach (tbl[k]) begin
            stall_i = tbl[k].stall;
            mem_gnt_i = tbl[k].gnt;
            step();
            chk($sformatf("vec%0d", k), snap(), tbl[k].exp);
        end
        stall_i = '0;
        fetch_word(32'd4, 0, w4);

        // Branch while waiting on byte 2 of the word at 8
        step();
        lat = 2;
        for (int i = 0; i < 40; i++) begin
            if (mem_req_o && mem_addr_o == 32'd10) break;
            step();
        end
        chk("br_reach", 98'({mem_req_o, mem_addr_o}), 98'({1'b1, 32'd10}));
        step();
        chk("br_wait", snap(), mk(0, 32'd10, 0, 32'd4, w4));
        branch_enable_i = 1'b1; branch_addr_i = 32'h100;
        step();
        chk("br_drain", snap(), mk(0, 32'd10, 0, 32'd4, w4));
        branch_enable_i = 1'b0; lat = 1;
        step();
        chk("br_refetch", snap(), mk(1, 32'h100, 0, 32'd4, w4));
        fetch_word(32'h100, 0, 32'hDEAD_BEEF);

        // Grant withheld at odd address 5
        bb = 32'hDEAD_BEEF;
        mem_gnt_i = 1'b0;
        branch_enable_i = 1'b1; branch_addr_i = 32'd5;
        step();
        chk("gnt_br", snap(), mk(1, 32'd5, 0, 32'h100, bb));
        branch_enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("gnt_hold%0d", i), snap(),
                mk(1, 32'd5, 0, 32'h100, bb));
        end
        mem_gnt_i = 1'b1;
        step();
        chk("gnt_wait", snap(), mk(0, 32'd5, 0, 32'h100, bb));
        wx = word_at(32'd5);
        fetch_word(32'd5, 1, wx);

        // rdy low in FETCH, then in WAIT with rvalid pending
        step();
        chk("rdy_fetch", snap(), mk(1, 32'd9, 0, 32'd5, wx));
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("rdy_f%0d", i), snap(), mk(1, 32'd9, 0, 32'd5, wx));
        end
        rdy = 1'b1;
        step();
        chk("rdy_wait", snap(), mk(0, 32'd9, 0, 32'd5, wx));
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("rdy_w%0d", i), snap(), mk(0, 32'd9, 0, 32'd5, wx));
        end
        rdy = 1'b1;
        step();
        chk("rdy_resume", snap(), mk(1, 32'd10, 0, 32'd5, wx));
        fetch_word(32'd9, 1, word_at(32'd9));

        // Reset with a byte outstanding, then stray rvalid in FETCH
        wx = word_at(32'd9);
        step();
        chk("rst_fetch", snap(), mk(1, 32'd13, 0, 32'd9, wx));
        lat = 2;
        step();
        chk("rst_wait", snap(), mk(0, 32'd13, 0, 32'd9, wx));
        rst = 1'b1;
        step();
        chk("rst_mid", snap(), mk(0, 0, 0, 0, 0));
        rst = 1'b0; lat = 1;
        step();
        chk("rst_refetch", snap(), mk(1, 0, 0, 0, 0));
        mem_gnt_i = 1'b0; force_rv = 1'b1;
        step();
        chk("stray_rv", snap(), mk(1, 0, 0, 0, 0));
        force_rv = 1'b0; mem_gnt_i = 1'b1;
        fetch_word(32'd0, 0, 32'h0000_0013);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
